// File: rtl/vfu_mask_router.sv
// -----------------------------------------------------------------------------
// vfu_mask_router
//
// Distributes mask strobe words from the mask unit to the mask inputs of the
// NrFUs functional units of one lane. Each FU owns a small circular FIFO of
// MaskDepth mask words.
//
// Build option:
//   ARA_MASK_TAGGED_EN defined   : tag-routed mode. Each word carries an
//                                  instruction ID and is pushed only into the
//                                  FIFO of the lowest-index FU whose active
//                                  instruction ID matches.
//   ARA_MASK_TAGGED_EN undefined : legacy broadcast mode. Each word is pushed
//                                  into every FU with an active masked
//                                  instruction. Tags are ignored and
//                                  err_multi_o is tied low.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   mask_i            mask strobe word (DataWidth/8 bits)
//   mask_id_i         instruction ID tag of mask_i
//   mask_valid_i      mask word valid
//   mask_ready_o      word accepted this cycle (combinational)
//   fu_vid_i          per-FU active masked instruction ID (packed, FU0 in LSBs)
//   fu_vid_valid_i    per-FU active masked instruction present
//   fu_flush_i        per-FU discard of all buffered masks
//   fu_mask_o         per-FU FIFO head (zero while the FIFO is empty)
//   fu_mask_valid_o   per-FU FIFO non-empty
//   fu_mask_ready_i   per-FU consume head
//   err_multi_o       sticky: an accepted tag matched more than one FU
//   orphan_stall_o    valid word held because no FU claims it (combinational)
// -----------------------------------------------------------------------------
module vfu_mask_router #(
    parameter int unsigned NrFUs     = 2,
    parameter int unsigned MaskDepth = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned VidWidth  = 3
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [DataWidth/8-1:0]           mask_i,
    input  logic [VidWidth-1:0]              mask_id_i,
    input  logic                             mask_valid_i,
    output logic                             mask_ready_o,
    input  logic [NrFUs*VidWidth-1:0]        fu_vid_i,
    input  logic [NrFUs-1:0]                 fu_vid_valid_i,
    input  logic [NrFUs-1:0]                 fu_flush_i,
    output logic [NrFUs*(DataWidth/8)-1:0]   fu_mask_o,
    output logic [NrFUs-1:0]                 fu_mask_valid_o,
    input  logic [NrFUs-1:0]                 fu_mask_ready_i,
    output logic                             err_multi_o,
    output logic                             orphan_stall_o
);

    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned CntW  = $clog2(MaskDepth + 1);
    localparam int unsigned PtrW  = (MaskDepth > 1) ? $clog2(MaskDepth) : 1;

    localparam logic [CntW-1:0] DepthCnt = CntW'(MaskDepth);
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(MaskDepth - 1);

    // Circular pointer increment, wrapping from the last slot back to slot 0.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == LastPtr) begin
            nxt = '0;
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    // FIFO state
    logic [StrbW-1:0]           mem_q [NrFUs][MaskDepth];
    logic [StrbW-1:0]           mem_d [NrFUs][MaskDepth];
    logic [NrFUs-1:0][PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [NrFUs-1:0][PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [NrFUs-1:0][CntW-1:0] cnt_q, cnt_d;

    // Per-FU handshake qualifiers
    logic [NrFUs-1:0] full_s;
    logic [NrFUs-1:0] pop_s;
    logic [NrFUs-1:0] push_s;
    logic             mask_ready_s;
    logic             orphan_stall_s;

    // Full/pop flags derive only from registered occupancy, so a pop never
    // frees a slot for a push in the same cycle.
    always_comb begin
        full_s = '0;
        pop_s  = '0;
        for (int i = 0; i < NrFUs; i++) begin
            full_s[i] = (cnt_q[i] == DepthCnt);
            pop_s[i]  = (cnt_q[i] != '0) && fu_mask_ready_i[i];
        end
    end

`ifdef ARA_MASK_TAGGED_EN
    logic [NrFUs-1:0] match_s;
    logic [NrFUs-1:0] target_s;
    logic             multi_s;
    logic             err_multi_q, err_multi_d;

    // Tag match vector across all FUs with an active masked instruction.
    always_comb begin
        match_s = '0;
        for (int i = 0; i < NrFUs; i++) begin
            match_s[i] = fu_vid_valid_i[i] &&
                         (fu_vid_i[i*VidWidth +: VidWidth] == mask_id_i);
        end
    end

    // Target selection (lowest matching index, isolated as a one-hot) and acceptance.
    always_comb begin
        target_s       = match_s & (~match_s + NrFUs'(1));
        multi_s        = ((match_s & ~target_s) != '0);
        mask_ready_s   = mask_valid_i &&
                         ((target_s & ~full_s & ~fu_flush_i) != '0);
        orphan_stall_s = mask_valid_i && (match_s == '0);
        push_s         = mask_ready_s ? target_s : '0;
        err_multi_d    = err_multi_q | (mask_ready_s & multi_s);
    end

    // Sticky multi-match error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_multi_q <= 1'b0;
        end else begin
            err_multi_q <= err_multi_d;
        end
    end

    assign err_multi_o = err_multi_q;
`else
    logic any_valid_s;
    logic blocked_s;
    logic unused_s;

    // Broadcast acceptance: every active FU must have room and not be flushing.
    always_comb begin
        any_valid_s    = (fu_vid_valid_i != '0);
        blocked_s      = ((fu_vid_valid_i & (full_s | fu_flush_i)) != '0);
        mask_ready_s   = mask_valid_i && any_valid_s && !blocked_s;
        orphan_stall_s = mask_valid_i && !any_valid_s;
        push_s         = mask_ready_s ? fu_vid_valid_i : '0;
    end

    assign unused_s    = ^{mask_id_i, fu_vid_i};
    assign err_multi_o = 1'b0;
`endif

    assign mask_ready_o   = mask_ready_s;
    assign orphan_stall_o = orphan_stall_s;

    // Next-state of every FU FIFO; flush overrides push and pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NrFUs; i++) begin
            if (fu_flush_i[i]) begin
                rd_ptr_d[i] = '0;
                wr_ptr_d[i] = '0;
                cnt_d[i]    = '0;
            end else begin
                if (push_s[i]) begin
                    mem_d[i][wr_ptr_q[i]] = mask_i;
                    wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
                end else begin
                    wr_ptr_d[i] = wr_ptr_q[i];
                end
                if (pop_s[i]) begin
                    rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
                end else begin
                    rd_ptr_d[i] = rd_ptr_q[i];
                end
                case ({push_s[i], pop_s[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + CntW'(1);
                    2'b01:   cnt_d[i] = cnt_q[i] - CntW'(1);
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
        end
    end

    // FIFO storage, pointers and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrFUs; i++) begin
                for (int j = 0; j < MaskDepth; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // FIFO heads; an empty FIFO presents zero rather than a stale entry.
    always_comb begin
        fu_mask_o       = '0;
        fu_mask_valid_o = '0;
        for (int i = 0; i < NrFUs; i++) begin
            fu_mask_valid_o[i] = (cnt_q[i] != '0);
            if (cnt_q[i] != '0) begin
                fu_mask_o[i*StrbW +: StrbW] = mem_q[i][rd_ptr_q[i]];
            end else begin
                fu_mask_o[i*StrbW +: StrbW] = '0;
            end
        end
    end

endmodule

// File: tb/tb_vfu_mask_router.sv
module tb_vfu_mask_router;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  mask_i;
    logic [2:0]  mask_id_i;
    logic        mask_valid_i;
    logic        mask_ready_o;
    logic [5:0]  fu_vid_i;
    logic [1:0]  fu_vid_valid_i;
    logic [1:0]  fu_flush_i;
    logic [15:0] fu_mask_o;
    logic [1:0]  fu_mask_valid_o;
    logic [1:0]  fu_mask_ready_i;
    logic        err_multi_o;
    logic        orphan_stall_o;

    int n_checks = 0;
    int n_errors = 0;

    vfu_mask_router #(
        .NrFUs(2), .MaskDepth(2), .DataWidth(64), .VidWidth(3)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mask_i(mask_i), .mask_id_i(mask_id_i), .mask_valid_i(mask_valid_i),
        .mask_ready_o(mask_ready_o),
        .fu_vid_i(fu_vid_i), .fu_vid_valid_i(fu_vid_valid_i), .fu_flush_i(fu_flush_i),
        .fu_mask_o(fu_mask_o), .fu_mask_valid_o(fu_mask_valid_o),
        .fu_mask_ready_i(fu_mask_ready_i),
        .err_multi_o(err_multi_o), .orphan_stall_o(orphan_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1ns after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_valid"},  {14'd0, fu_mask_valid_o}, 16'h0000);
        check({pfx, "_data"},   fu_mask_o, 16'h0000);
        check({pfx, "_err"},    {15'd0, err_multi_o}, 16'h0000);
        check({pfx, "_ready"},  {15'd0, mask_ready_o}, 16'h0000);
        check({pfx, "_orphan"}, {15'd0, orphan_stall_o}, 16'h0000);
    endtask

    initial begin
        rst_ni          = 1'b0;
        mask_i          = 8'h00;
        mask_id_i       = 3'd0;
        mask_valid_i    = 1'b0;
        fu_vid_i        = 6'd0;
        fu_vid_valid_i  = 2'b00;
        fu_flush_i      = 2'b00;
        fu_mask_ready_i = 2'b00;
        #3;
        reset_checks("rst");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

`ifdef ARA_MASK_TAGGED_EN
        // Basic route: tag 3 goes to FU1 only
        fu_vid_i = {3'd3, 3'd2}; fu_vid_valid_i = 2'b11;
        mask_i = 8'hA5; mask_id_i = 3'd3; mask_valid_i = 1'b1;
        #1;
        check("route_ready", {15'd0, mask_ready_o}, 16'h0001);
        check("route_orphan", {15'd0, orphan_stall_o}, 16'h0000);
        tick();
        mask_valid_i = 1'b0;
        check("route_valid", {14'd0, fu_mask_valid_o}, 16'h0002);
        check("route_data", fu_mask_o, 16'hA500);
        fu_mask_ready_i = 2'b10;
        tick();
        check("route_popped", {14'd0, fu_mask_valid_o}, 16'h0000);
        fu_mask_ready_i = 2'b00;

        // Back-pressure on FU0 (tag 2), depth 2
        mask_id_i = 3'd2; mask_valid_i = 1'b1; mask_i = 8'h01;
        tick();
        mask_i = 8'h02;
        tick();
        mask_i = 8'h03;
        #1;
        check("bp_full_ready", {15'd0, mask_ready_o}, 16'h0000);
        check("bp_head1", fu_mask_o, 16'h0001);
        fu_mask_ready_i = 2'b01;
        #1;
        check("bp_pop_no_free", {15'd0, mask_ready_o}, 16'h0000);
        tick();
        check("bp_head2", fu_mask_o, 16'h0002);
        check("bp_ready_again", {15'd0, mask_ready_o}, 16'h0001);
        tick();
        mask_valid_i = 1'b0;
        check("bp_head3", fu_mask_o, 16'h0003);
        check("bp_valid3", {14'd0, fu_mask_valid_o}, 16'h0001);
        tick();
        check("bp_empty", {14'd0, fu_mask_valid_o}, 16'h0000);

        // Orphan: tag 5 with no FU at 5
        fu_mask_ready_i = 2'b11;
        mask_i = 8'h55; mask_id_i = 3'd5; mask_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("orphan_stall", {15'd0, orphan_stall_o}, 16'h0001);
            check("orphan_ready", {15'd0, mask_ready_o}, 16'h0000);
            tick();
        end
        check("orphan_no_push", {14'd0, fu_mask_valid_o}, 16'h0000);
        fu_vid_i = {3'd3, 3'd5};
        #1;
        check("orphan_claim_ready", {15'd0, mask_ready_o}, 16'h0001);
        check("orphan_claim_stall", {15'd0, orphan_stall_o}, 16'h0000);
        tick();
        mask_valid_i = 1'b0;
        check("orphan_delivered", fu_mask_o, 16'h0055);
        tick();
        fu_mask_ready_i = 2'b00;

        // Flush collision on FU0
        mask_i = 8'h11; mask_id_i = 3'd5; mask_valid_i = 1'b1;
        tick();
        check("flush_pre_valid", {14'd0, fu_mask_valid_o}, 16'h0001);
        mask_i = 8'h22; fu_flush_i = 2'b01;
        #1;
        check("flush_ready", {15'd0, mask_ready_o}, 16'h0000);
        tick();
        fu_flush_i = 2'b00;
        check("flush_cleared", {14'd0, fu_mask_valid_o}, 16'h0000);
        #1;
        check("flush_ready_after", {15'd0, mask_ready_o}, 16'h0001);
        tick();
        mask_valid_i = 1'b0;
        check("flush_accepted", fu_mask_o, 16'h0022);
        fu_flush_i = 2'b01;
        tick();
        fu_flush_i = 2'b00;

        // Multi-match: both FUs at vid 4
        fu_vid_i = {3'd4, 3'd4};
        mask_i = 8'h77; mask_id_i = 3'd4; mask_valid_i = 1'b1;
        tick();
        mask_valid_i = 1'b0;
        check("multi_valid", {14'd0, fu_mask_valid_o}, 16'h0001);
        check("multi_data", fu_mask_o, 16'h0077);
        check("multi_err", {15'd0, err_multi_o}, 16'h0001);
        tick();
        check("multi_err_sticky", {15'd0, err_multi_o}, 16'h0001);
        #2;
        rst_ni = 1'b0;
        #1;
        reset_checks("arst");
        #4;
        rst_ni = 1'b1;
        tick();
        check("arst_err_stays0", {15'd0, err_multi_o}, 16'h0000);
`else
        // Legacy broadcast to both valid FUs
        fu_vid_valid_i = 2'b11;
        mask_i = 8'h3C; mask_valid_i = 1'b1;
        #1;
        check("bc_ready", {15'd0, mask_ready_o}, 16'h0001);
        check("bc_orphan", {15'd0, orphan_stall_o}, 16'h0000);
        tick();
        mask_valid_i = 1'b0;
        check("bc_valid", {14'd0, fu_mask_valid_o}, 16'h0003);
        check("bc_data", fu_mask_o, 16'h3C3C);
        check("bc_err_tied", {15'd0, err_multi_o}, 16'h0000);
        fu_mask_ready_i = 2'b11;
        tick();
        check("bc_popped", {14'd0, fu_mask_valid_o}, 16'h0000);
        fu_mask_ready_i = 2'b00;

        // Fill FU1 only, then a broadcast must stall
        fu_vid_valid_i = 2'b10;
        mask_i = 8'h01; mask_valid_i = 1'b1;
        tick();
        mask_i = 8'h02;
        tick();
        check("fill_valid", {14'd0, fu_mask_valid_o}, 16'h0002);
        fu_vid_valid_i = 2'b11; mask_i = 8'h03;
        #1;
        check("full_ready", {15'd0, mask_ready_o}, 16'h0000);
        check("full_orphan", {15'd0, orphan_stall_o}, 16'h0000);
        tick();
        check("full_no_push", {14'd0, fu_mask_valid_o}, 16'h0002);
        check("full_head", fu_mask_o, 16'h0100);

        // No valid FU: orphan
        fu_vid_valid_i = 2'b00;
        #1;
        check("orphan_stall", {15'd0, orphan_stall_o}, 16'h0001);
        check("orphan_ready", {15'd0, mask_ready_o}, 16'h0000);

        // Pop FU1 in order while the pending word waits for a free slot
        fu_vid_valid_i = 2'b10; fu_mask_ready_i = 2'b10;
        tick();
        check("pop_head2", fu_mask_o, 16'h0200);
        tick();
        mask_valid_i = 1'b0;
        check("pop_head3", fu_mask_o, 16'h0300);
        fu_mask_ready_i = 2'b00;

        // Flush FU1 while presenting a word
        mask_i = 8'h44; mask_valid_i = 1'b1; fu_flush_i = 2'b10;
        #1;
        check("flush_ready", {15'd0, mask_ready_o}, 16'h0000);
        tick();
        fu_flush_i = 2'b00;
        check("flush_cleared", {14'd0, fu_mask_valid_o}, 16'h0000);
        tick();
        mask_valid_i = 1'b0;
        check("flush_accepted", fu_mask_o, 16'h4400);

        // Asynchronous reset mid-cycle
        #2;
        rst_ni = 1'b0;
        #1;
        reset_checks("arst");
        #4;
        rst_ni = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
